// File: rtl/pico_acc_core.sv
// Accumulator core: single-cycle ALU ops, multi-cycle shifts and an
// iterative shift-add multiplier, with a simple read/write data bus.
module pico_acc_core #(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 12,
  parameter int CARRY_ADDR = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IMM_W+3:0]   instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               busy,
  output logic               rw_req,
  output logic               rw_rnw,
  output logic [IMM_W-1:0]   rw_addr,
  input  logic [DATA_W-1:0]  data_to_rd,
  output logic [DATA_W-1:0]  data_to_wr,
  output logic [DATA_W-1:0]  regA,
  output logic [DATA_W-1:0]  regC
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_RDW  = 4'h3;
  localparam logic [3:0] OP_WRW  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MULT} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic                shift_left;
  logic [DATA_W-1:0]   mul_a, mul_b;

  logic [3:0]          opcode;
  logic [IMM_W-1:0]    imm;
  logic [SH_W-1:0]     sh_n;
  logic                accept, is_carry, reads_operand, multi_cycle;
  logic [DATA_W-1:0]   operand, imm_sext;
  logic [DATA_W:0]     add_full, sub_full;

  assign opcode      = instruction[IMM_W+3 -: 4];
  assign imm         = instruction[IMM_W-1:0];
  assign sh_n        = imm[SH_W-1:0];
  assign busy        = (state != S_IDLE);
  assign instr_ready = !busy;
  assign accept      = instr_valid && instr_ready;
  assign is_carry    = (imm == IMM_W'(CARRY_ADDR));
  assign operand     = is_carry ? regC : data_to_rd;
  assign imm_sext    = DATA_W'($signed(imm));
  assign add_full    = {1'b0, regA} + {1'b0, operand};
  assign sub_full    = {1'b0, regA} + {1'b0, ~operand} + {{DATA_W{1'b0}}, 1'b1};
  assign multi_cycle = (((opcode == OP_SHL) || (opcode == OP_SHR)) && (sh_n != '0))
                       || (opcode == OP_MUL);

  assign rw_req     = accept && ((reads_operand && !is_carry) || (opcode == OP_WRW));
  assign rw_rnw     = (opcode != OP_WRW);
  assign rw_addr    = imm;
  assign data_to_wr = regA;

  // Decode which opcodes consume a bus/carry operand
  always_comb begin
    reads_operand = 1'b0;
    case (opcode)
      OP_RDW, OP_ADD, OP_SUB, OP_AND, OP_MUL: reads_operand = 1'b1;
      default:                                reads_operand = 1'b0;
    endcase
  end

  // State register; reset always returns to IDLE, aborting any running op
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state: leave IDLE on a multi-cycle accept, return when the count expires
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:          if (accept && multi_cycle)
                         state_n = (opcode == OP_MUL) ? S_MULT : S_SHIFT;
      S_SHIFT, S_MULT: if (cnt == CNT_W'(1)) state_n = S_IDLE;
      default:         state_n = S_IDLE;
    endcase
  end

  // Datapath: execute accepted ops in IDLE, step shifts and multiply while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      regA       <= '0;
      regC       <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_LDI:  regA <= imm_sext;
              OP_ADDI: regA <= regA + imm_sext;
              OP_RDW:  regA <= operand;
              OP_ADD: begin
                regA <= add_full[DATA_W-1:0];
                regC <= {{(DATA_W-1){1'b0}}, add_full[DATA_W]};
              end
              OP_SUB: begin
                regA <= sub_full[DATA_W-1:0];
                regC <= {{(DATA_W-1){1'b0}}, sub_full[DATA_W]};
              end
              OP_AND:  regA <= regA & operand;
              OP_SHL, OP_SHR: begin
                if (sh_n != '0) begin
                  cnt        <= CNT_W'(sh_n);
                  shift_left <= (opcode == OP_SHL);
                end
              end
              OP_MUL: begin
                cnt   <= CNT_W'(DATA_W);
                mul_a <= operand;
                mul_b <= regA;
                regA  <= '0;
              end
              default: ;
            endcase
          end
        end
        S_SHIFT: begin
          regA <= shift_left ? (regA << 1) : (regA >> 1);
          cnt  <= cnt - 1'b1;
        end
        S_MULT: begin
          if (mul_b[0]) regA <= regA + mul_a;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_acc_core.sv
// Self-checking bench for pico_acc_core: a behavioural model pushes expected
// register values to a scoreboard as each instruction is driven; each test
// pops and compares once the DUT has finished the instruction.
module tb_pico_acc_core;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_RDW  = 4'h3;
  localparam logic [3:0] OP_WRW  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        rw_req;
  logic        rw_rnw;
  logic [11:0] rw_addr;
  logic [15:0] data_to_rd;
  logic [15:0] data_to_wr;
  logic [15:0] regA;
  logic [15:0] regC;

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] c;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] model_a;
  logic [15:0] model_c;
  int          n_checks;
  int          n_fail;

  pico_acc_core #(.DATA_W(16), .IMM_W(12), .CARRY_ADDR(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .rw_req      (rw_req),
    .rw_rnw      (rw_rnw),
    .rw_addr     (rw_addr),
    .data_to_rd  (data_to_rd),
    .data_to_wr  (data_to_wr),
    .regA        (regA),
    .regC        (regC)
  );

  always #5 clk = ~clk;

  // Drive an instruction at the falling edge, advance the model and push its expectation
  task automatic drive_op(input logic [3:0] op, input logic [11:0] imm, input logic [15:0] rd);
    logic [15:0] o;
    logic [15:0] sx;
    logic [16:0] s;
    @(negedge clk);
    instruction = {op, imm};
    data_to_rd  = rd;
    instr_valid = 1'b1;
    o  = (imm == 12'd2) ? model_c : rd;
    sx = {{4{imm[11]}}, imm};
    case (op)
      OP_LDI:  model_a = sx;
      OP_ADDI: model_a = model_a + sx;
      OP_RDW:  model_a = o;
      OP_ADD: begin
        s       = {1'b0, model_a} + {1'b0, o};
        model_a = s[15:0];
        model_c = {15'd0, s[16]};
      end
      OP_SUB: begin
        model_c = (model_a >= o) ? 16'd1 : 16'd0;
        model_a = model_a - o;
      end
      OP_AND:  model_a = model_a & o;
      OP_SHL:  model_a = model_a << imm[3:0];
      OP_SHR:  model_a = model_a >> imm[3:0];
      OP_MUL:  model_a = 16'(model_a * o);
      default: ;
    endcase
    sb.push_back('{$sformatf("op%0h_imm%0h", op, imm), model_a, model_c});
    #1;
  endtask

  // Let the accept edge happen, then withdraw the instruction
  task automatic commit_op;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    instruction = {OP_LDI, 12'h005};
    instr_valid = 1'b1;
    data_to_rd  = 16'h0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    model_a     = 16'h0;
    model_c     = 16'h0;
    sb.delete();
    n_checks++;
    if (regA !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_regA: got %h, want 0000", regA); end
    n_checks++;
    if (regC !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_regC: got %h, want 0000", regC); end
    n_checks++;
    if (busy !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_busy: busy=%b ready=%b, want busy=0 ready=1", busy, instr_ready);
    end
    n_checks++;
    if (data_to_wr !== 16'h0 || rw_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_bus: wr=%h req=%b, want wr=0000 req=0", data_to_wr, rw_req);
    end
  endtask

  task automatic test_write;
    drive_op(OP_LDI, 12'h003, 16'h0);
    commit_op();
    e = sb.pop_front();
    n_checks++;
    if (regA !== e.a || regC !== e.c) begin
      n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
    end
    drive_op(OP_WRW, 12'h006, 16'h0);
    n_checks++;
    if (rw_req !== 1'b1 || rw_rnw !== 1'b0 || rw_addr !== 12'h006 || data_to_wr !== 16'h0003) begin
      n_fail++;
      $display("[TB] FAIL wrw_bus: req=%b rnw=%b addr=%h wr=%h, want req=1 rnw=0 addr=006 wr=0003",
               rw_req, rw_rnw, rw_addr, data_to_wr);
    end
    commit_op();
    e = sb.pop_front();
    n_checks++;
    if (regA !== e.a || regC !== e.c) begin
      n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
    end
  endtask

  task automatic test_multiword_add;
    logic [3:0]  ops [4] = '{OP_RDW, OP_ADD, OP_RDW, OP_ADD};
    logic [11:0] imms[4] = '{12'd3, 12'd4, 12'd5, 12'd2};
    logic [15:0] rds [4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hBEEF};
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], imms[i], rds[i]);
      n_checks++;
      if (i == 3) begin
        if (rw_req !== 1'b0) begin n_fail++; $display("[TB] FAIL carry_operand_req: got %b, want 0", rw_req); end
      end else begin
        if (rw_req !== 1'b1 || rw_rnw !== 1'b1 || rw_addr !== imms[i]) begin
          n_fail++; $display("[TB] FAIL read_req_%0d: req=%b rnw=%b addr=%h, want 1 1 %h", i, rw_req, rw_rnw, rw_addr, imms[i]);
        end
      end
      commit_op();
      e = sb.pop_front();
      n_checks++;
      if (regA !== e.a || regC !== e.c) begin
        n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
      end
    end
    n_checks++;
    if (regA !== 16'h0001) begin n_fail++; $display("[TB] FAIL multiword_result: got %h, want 0001", regA); end
  endtask

  task automatic test_sub;
    logic [3:0]  ops [4] = '{OP_LDI, OP_SUB, OP_ADD, OP_ADDI};
    logic [11:0] imms[4] = '{12'd5, 12'd7, 12'd2, 12'hFFF};
    logic [15:0] rds [4] = '{16'h0, 16'h0007, 16'h1234, 16'h0};
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], imms[i], rds[i]);
      commit_op();
      e = sb.pop_front();
      n_checks++;
      if (regA !== e.a || regC !== e.c) begin
        n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
      end
      if (i == 1) begin
        n_checks++;
        if (regA !== 16'hFFFE || regC !== 16'h0) begin
          n_fail++; $display("[TB] FAIL sub_borrow: regA=%h regC=%h, want FFFE 0000", regA, regC);
        end
      end
    end
    n_checks++;
    if (regA !== 16'hFFFD) begin n_fail++; $display("[TB] FAIL sub_chain: got %h, want FFFD", regA); end
  endtask

  task automatic test_stall_nop;
    @(negedge clk);
    instruction = {OP_ADDI, 12'hFFE};
    instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (regA !== model_a) begin n_fail++; $display("[TB] FAIL stall_%0d: regA=%h, want %h", k, regA, model_a); end
    end
    drive_op(OP_ADDI, 12'hFFE, 16'h0);
    commit_op();
    e = sb.pop_front();
    n_checks++;
    if (regA !== e.a || regA !== 16'hFFFB) begin
      n_fail++; $display("[TB] FAIL %s: regA=%h, want %h", e.tag, regA, 16'hFFFB);
    end
    drive_op(4'hC, 12'h0A5, 16'h5555);
    commit_op();
    e = sb.pop_front();
    n_checks++;
    if (regA !== e.a || regC !== e.c) begin
      n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
    end
  endtask

  task automatic test_shift;
    logic [3:0]  ops [3] = '{OP_SHL, OP_SHR, OP_SHR};
    logic [11:0] imms[3] = '{12'h004, 12'h003, 12'h000};
    int          cyc_want[3] = '{4, 3, 0};
    int          cyc;
    drive_op(OP_LDI, 12'h123, 16'h0);
    commit_op();
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], imms[i], 16'h0);
      commit_op();
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
        cyc++;
        @(negedge clk);
        instruction = {OP_ADDI, 12'h001};
        instr_valid = 1'b1;
        #1;
        if (i == 0 && cyc == 1) begin
          n_checks++;
          if (rw_req !== 1'b0 || instr_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL busy_ignore: req=%b ready=%b, want 0 0", rw_req, instr_ready);
          end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
      end
      n_checks++;
      if (cyc != cyc_want[i]) begin n_fail++; $display("[TB] FAIL shift_busy_%0d: got %0d cycles, want %0d", i, cyc, cyc_want[i]); end
      e = sb.pop_front();
      n_checks++;
      if (regA !== e.a || regC !== e.c) begin
        n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
      end
      if (i == 0) begin
        n_checks++;
        if (regA !== 16'h1230) begin n_fail++; $display("[TB] FAIL shl4_value: got %h, want 1230", regA); end
      end
    end
  endtask

  task automatic test_mul;
    int cyc;
    drive_op(OP_LDI, 12'h012, 16'h0);
    commit_op();
    e = sb.pop_front();
    drive_op(OP_MUL, 12'h007, 16'h0034);
    n_checks++;
    if (rw_req !== 1'b1 || rw_rnw !== 1'b1) begin n_fail++; $display("[TB] FAIL mul_read: req=%b rnw=%b, want 1 1", rw_req, rw_rnw); end
    commit_op();
    data_to_rd = 16'hFFFF;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (cyc != 16) begin n_fail++; $display("[TB] FAIL mul_busy: got %0d cycles, want 16", cyc); end
    e = sb.pop_front();
    n_checks++;
    if (regA !== e.a || regA !== 16'h03A8 || regC !== e.c) begin
      n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=03a8 regC=%h", e.tag, regA, regC, e.c);
    end
    // Repeat, aborting with reset in the fifth busy cycle
    drive_op(OP_LDI, 12'h012, 16'h0);
    commit_op();
    e = sb.pop_front();
    drive_op(OP_MUL, 12'h007, 16'h0034);
    commit_op();
    for (int k = 1; k < 5; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mul_busy_c5: got %b, want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    model_a = 16'h0;
    model_c = 16'h0;
    n_checks++;
    if (regA !== 16'h0 || busy !== 1'b0 || regC !== 16'h0) begin
      n_fail++; $display("[TB] FAIL mul_abort: regA=%h busy=%b regC=%h, want 0000 0 0000", regA, busy, regC);
    end
    drive_op(OP_ADDI, 12'h001, 16'h0);
    commit_op();
    e = sb.pop_front();
    n_checks++;
    if (regA !== e.a || regC !== e.c) begin
      n_fail++; $display("[TB] FAIL %s: regA=%h regC=%h, want regA=%h regC=%h", e.tag, regA, regC, e.a, e.c);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  pool[7] = '{OP_NOP, OP_LDI, OP_ADDI, OP_RDW, OP_ADD, OP_SUB, OP_AND};
    logic [3:0]  op;
    logic [11:0] imm;
    logic [15:0] rd;
    logic        want_req;
    for (int i = 0; i < 30; i++) begin
      op  = pool[$urandom_range(0, 6)];
      imm = ($urandom_range(0, 3) == 0) ? 12'd2 : 12'($urandom);
      rd  = 16'($urandom);
      want_req = (op == OP_RDW || op == OP_ADD || op == OP_SUB || op == OP_AND) && (imm != 12'd2);
      drive_op(op, imm, rd);
      n_checks++;
      if (rw_req !== want_req) begin n_fail++; $display("[TB] FAIL b2b_req_%0d: got %b, want %b", i, rw_req, want_req); end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (regA !== e.a || regC !== e.c) begin
        n_fail++; $display("[TB] FAIL b2b_%0d %s: regA=%h regC=%h, want regA=%h regC=%h", i, e.tag, regA, regC, e.a, e.c);
      end
    end
    instr_valid = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_a  = 16'h0;
    model_c  = 16'h0;
    test_reset();
    test_write();
    test_multiword_add();
    test_sub();
    test_stall_nop();
    test_shift();
    test_mul();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the bench itself stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
